ysyx_22050612_wb_arbiter: RTL

Writeback arbiter that feeds the single write port of the NPC integer register file. It accepts results from two producers, the ALU path and the LSU path, through independent valid/ready handshakes, and buffers each in a 2-entry FIFO. It arbitrates round-robin between the two FIFOs and drives one registered `wen`/`waddr`/`wdata` triple per cycle. It is the writer end of the register-file write interface, and it also filters writes to x0.

---
 rtl/ysyx_22050612_wb_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/ysyx_22050612_wb_arbiter.sv
// Writeback arbiter: two buffered producers (ALU, LSU) share the single
// register-file write port under round-robin arbitration, with x0 writes dropped.
module ysyx_22050612_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  idle
);

    localparam int unsigned NSRC  = 2;
    localparam int unsigned DEPTH = 2;
    localparam logic        SRC_ALU = 1'b0;
    localparam logic        SRC_LSU = 1'b1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    logic      [NSRC-1:0] src_valid;
    wb_entry_t [NSRC-1:0] src_entry;
    logic      [NSRC-1:0] src_ready_c;
    logic      [NSRC-1:0] push;
    logic      [NSRC-1:0] pop;
    logic      [NSRC-1:0] nonempty;
    wb_entry_t [NSRC-1:0] head_s;
    wb_entry_t            head;
    logic                 last_grant;

    assign src_valid    = {lsu_valid, alu_valid};
    assign src_entry[0] = {alu_rd, alu_data};
    assign src_entry[1] = {lsu_rd, lsu_data};
    assign alu_ready    = src_ready_c[0];
    assign lsu_ready    = src_ready_c[1];

    // Per-source 2-entry FIFO; rd==0 completes the handshake without storing.
    for (genvar g = 0; g < NSRC; g++) begin : g_fifo
        wb_entry_t  mem [DEPTH];
        logic [1:0] count;
        logic       wptr;
        logic       rptr;

        assign src_ready_c[g] = rst_n && (count != 2'd2);
        assign push[g]        = src_valid[g] && src_ready_c[g] && (src_entry[g].rd != '0);
        assign nonempty[g]    = (count != 2'd0);
        assign head_s[g]      = mem[rptr];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count <= 2'd0;
                wptr  <= 1'b0;
                rptr  <= 1'b0;
            end else begin
                count <= count + 2'(push[g]) - 2'(pop[g]);
                if (push[g]) wptr <= ~wptr;
                if (pop[g])  rptr <= ~rptr;
            end
        end

        always_ff @(posedge clk) begin
            if (push[g]) mem[wptr] <= src_entry[g];
        end
    end

    // Round-robin: on a tie the source that was not granted last wins.
    always_comb begin
        pop = '0;
        if (nonempty[SRC_ALU] && (!nonempty[SRC_LSU] || last_grant == SRC_LSU)) begin
            pop[SRC_ALU] = 1'b1;
        end else if (nonempty[SRC_LSU]) begin
            pop[SRC_LSU] = 1'b1;
        end
    end

    assign head = pop[SRC_LSU] ? head_s[SRC_LSU] : head_s[SRC_ALU];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen        <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            last_grant <= SRC_LSU;
        end else begin
            wen <= |pop;
            if (|pop) begin
                waddr      <= head.rd;
                wdata      <= head.data;
                last_grant <= pop[SRC_LSU];
            end
        end
    end

    assign idle = !(|nonempty) && !wen;

endmodule
